// File: rtl/piece_writer_pkg.sv
// Shared types for the piece writer.
//   mode_t  : operation requested by the game-control FSM
//   state_t : piece_writer sequencer states
package piece_writer_pkg;

  typedef enum logic [1:0] {
    MODE_PLACE = 2'b00,
    MODE_ERASE = 2'b01,
    MODE_TRY   = 2'b10,
    MODE_PROBE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHECK = 2'b01,
    S_WRITE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Modes that read the board before (possibly) writing it.
  function automatic logic is_check(mode_t m);
    return (m == MODE_TRY) || (m == MODE_PROBE);
  endfunction

endpackage

// File: rtl/piece_writer_if.sv
// Bundle between the game-control side (plus board RAM) and the piece writer.
//   en/mode/color/cell_addr : request from game control
//   busy/done/collision     : status back to game control
//   mem_we/mem_addr/mem_wdata/mem_rdata : single-port board RAM bus
// master = game control + RAM environment, slave = piece_writer.
interface piece_writer_if #(
  parameter int N_CELLS = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic                      en;
  logic [1:0]                mode;
  logic [DATA_W-1:0]         color;
  logic [N_CELLS*ADDR_W-1:0] cell_addr;
  logic                      busy;
  logic                      done;
  logic                      collision;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport master (
    output en, mode, color, cell_addr, mem_rdata,
    input  busy, done, collision, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  en, mode, color, cell_addr, mem_rdata,
    output busy, done, collision, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/piece_writer_cell_select.sv
// Picks cell[idx] out of the flattened cell list and flags whether it lies
// on the board. idx values >= N_CELLS select address 0 and report out of range.
//   cells    : flattened cell addresses, cell i at [i*ADDR_W +: ADDR_W]
//   idx      : cell index
//   addr     : selected address
//   in_range : addr < BOARD_CELLS
module piece_writer_cell_select #(
  parameter int N_CELLS     = 4,
  parameter int ADDR_W      = 8,
  parameter int BOARD_CELLS = 200,
  parameter int IDX_W       = $clog2(N_CELLS + 1)
) (
  input  logic [N_CELLS*ADDR_W-1:0] cells,
  input  logic [IDX_W-1:0]          idx,
  output logic [ADDR_W-1:0]         addr,
  output logic                      in_range
);

  logic hit;

  always_comb begin
    addr = '0;
    hit  = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (idx == IDX_W'(i)) begin
        addr = cells[i*ADDR_W +: ADDR_W];
        hit  = 1'b1;
      end
    end
    in_range = hit && (int'(addr) < BOARD_CELLS);
  end

endmodule

// File: rtl/piece_writer.sv
// Writes the N cells of a piece into the board RAM, with erase, collision
// check (try-place / probe) and a guard for wall/floor addresses.
//   clk : system clock (rising edge)
//   rst : synchronous active-low reset
//   bus : request/status and board RAM bus (slave side)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for en; captures mode, colour and cells
//   S_CHECK | N+1 cycles: address cell j, evaluate rdata of cell j-1
//   S_WRITE | N cycles: write colour/EMPTY to each on-board cell
//   S_DONE  | one-cycle done pulse, then back to idle
module piece_writer
  import piece_writer_pkg::*;
#(
  parameter int                N_CELLS     = 4,
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                BOARD_CELLS = 200,
  parameter logic [DATA_W-1:0] EMPTY       = '0
) (
  input logic           clk,
  input logic           rst,
  piece_writer_if.slave bus
);

  localparam int IDX_W = $clog2(N_CELLS + 1);

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  mode_t                     mode_q;
  logic [DATA_W-1:0]         color_q;
  logic [N_CELLS*ADDR_W-1:0] cells_q;
  logic                      acc, acc_nxt;
  logic                      collision_q, collision_nxt;
  logic                      prev_oor;
  logic [ADDR_W-1:0]         sel_addr;
  logic                      sel_in_range;

  piece_writer_cell_select #(
    .N_CELLS(N_CELLS), .ADDR_W(ADDR_W), .BOARD_CELLS(BOARD_CELLS), .IDX_W(IDX_W)
  ) u_sel (
    .cells    (cells_q),
    .idx      (idx),
    .addr     (sel_addr),
    .in_range (sel_in_range)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      mode_q      <= MODE_PLACE;
      color_q     <= '0;
      cells_q     <= '0;
      acc         <= 1'b0;
      collision_q <= 1'b0;
      prev_oor    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      acc         <= acc_nxt;
      collision_q <= collision_nxt;
      // Range result of the cell addressed this cycle, used next cycle
      // alongside its read data.
      prev_oor    <= !sel_in_range;
      if (state == S_IDLE && bus.en) begin
        mode_q  <= mode_t'(bus.mode);
        color_q <= bus.color;
        cells_q <= bus.cell_addr;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    acc_nxt       = acc;
    collision_nxt = collision_q;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    bus.busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (bus.en) begin
          idx_nxt       = '0;
          acc_nxt       = 1'b0;
          collision_nxt = 1'b0;
          state_nxt     = is_check(mode_t'(bus.mode)) ? S_CHECK : S_WRITE;
        end
      end

      S_CHECK: begin
        bus.mem_addr = sel_addr;
        if (idx != '0)
          acc_nxt = acc | prev_oor | (bus.mem_rdata != EMPTY);
        if (idx == IDX_W'(N_CELLS)) begin
          idx_nxt       = '0;
          collision_nxt = acc_nxt;
          state_nxt     = (mode_q == MODE_TRY && !acc_nxt) ? S_WRITE : S_DONE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

      S_WRITE: begin
        if (sel_in_range) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = sel_addr;
          bus.mem_wdata = (mode_q == MODE_ERASE) ? EMPTY : color_q;
        end
        if (idx == IDX_W'(N_CELLS - 1)) begin
          idx_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    bus.collision = collision_q;
  end

endmodule

// File: tb/tb_piece_writer.sv
module tb_piece_writer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piece_writer_if #(.N_CELLS(4), .ADDR_W(8), .DATA_W(8)) bus ();

  piece_writer #(
    .N_CELLS(4), .ADDR_W(8), .DATA_W(8), .BOARD_CELLS(200), .EMPTY(8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Board RAM model: write on the edge, read data one cycle after address.
  logic [7:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_cyc, first_we;
  int wr_addr[$];
  int wr_data[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Cycle k = k-th negedge after capture.
  task automatic run_op(input logic [1:0] m, input logic [7:0] col,
                        input logic [31:0] cells, input bit poke_en);
    wr_addr.delete();
    wr_data.delete();
    done_cyc = 0;
    first_we = 0;
    bus.en = 1'b1; bus.mode = m; bus.color = col; bus.cell_addr = cells;
    for (int k = 1; k <= 30 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_c1", int'(bus.busy), 1);
      if (bus.mem_we) begin
        wr_addr.push_back(int'(bus.mem_addr));
        wr_data.push_back(int'(bus.mem_wdata));
        if (first_we == 0) first_we = k;
      end
      if (bus.done) done_cyc = k;
      if (k == 1) begin
        // Inputs changing after capture must not matter.
        bus.en = 1'b0; bus.mode = ~m; bus.color = ~col; bus.cell_addr = ~cells;
      end
      if (poke_en) bus.en = (k == 2);
    end
    if (done_cyc == 0) chk("timeout", 0, 1);
  endtask

  // After the done cycle: busy low, no further done pulses, collision held.
  task automatic post(input string tag, input int exp_coll);
    int extra;
    extra = 0;
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
    chk({tag, "_coll"}, int'(bus.collision), exp_coll);
    for (int k = 0; k < 6; k++) begin
      if (bus.done) extra++;
      if (k < 5) @(negedge clk);
    end
    chk({tag, "_extra_done"}, extra, 0);
    chk({tag, "_coll_held"}, int'(bus.collision), exp_coll);
  endtask

  task automatic check_wr(input string tag, input int n, input logic [31:0] addrs,
                          input int d);
    chk({tag, "_nwr"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({tag, "_wa"}, wr_addr[i], int'(addrs[i*8 +: 8]));
      chk({tag, "_wd"}, wr_data[i], d);
    end
  endtask

  initial begin
    int nd;
    rst = 1'b0;
    bus.en = 1'b0; bus.mode = 2'b00; bus.color = 8'h00; bus.cell_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_we",   int'(bus.mem_we), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_wd",   int'(bus.mem_wdata), 0);
    chk("rst_coll", int'(bus.collision), 0);
    rst = 1'b1;
    @(negedge clk);

    // PLACE {10,11,12,22} colour 5
    run_op(2'b00, 8'd5, {8'd22, 8'd12, 8'd11, 8'd10}, 1'b0);
    chk("place_done", done_cyc, 5);
    chk("place_first_we", first_we, 1);
    check_wr("place", 4, {8'd22, 8'd12, 8'd11, 8'd10}, 5);
    post("place", 0);

    // ERASE the same cells
    run_op(2'b01, 8'd5, {8'd22, 8'd12, 8'd11, 8'd10}, 1'b0);
    chk("erase_done", done_cyc, 5);
    check_wr("erase", 4, {8'd22, 8'd12, 8'd11, 8'd10}, 0);
    post("erase", 0);

    // TRY_PLACE on free cells {0,1,2,3}: 5 checks then 4 writes
    run_op(2'b10, 8'd7, {8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
    chk("try_ok_done", done_cyc, 10);
    chk("try_ok_first_we", first_we, 6);
    check_wr("try_ok", 4, {8'd3, 8'd2, 8'd1, 8'd0}, 7);
    post("try_ok", 0);

    // Preload RAM[12]=3 (the 205 cells are floor, not written)
    run_op(2'b00, 8'd3, {8'd205, 8'd205, 8'd205, 8'd12}, 1'b0);
    chk("pre_done", done_cyc, 5);
    check_wr("pre", 1, {24'd0, 8'd12}, 3);
    post("pre", 0);

    // TRY_PLACE colliding on cell 12
    run_op(2'b10, 8'd7, {8'd22, 8'd12, 8'd11, 8'd10}, 1'b0);
    chk("try_bad_done", done_cyc, 6);
    chk("try_bad_nwr", wr_addr.size(), 0);
    post("try_bad", 1);
    chk("try_bad_ram12", int'(ram[12]), 3);
    chk("try_bad_ram10", int'(ram[10]), 0);

    run_op(2'b01, 8'd9, {8'd22, 8'd12, 8'd11, 8'd10}, 1'b0);
    chk("erase2_done", done_cyc, 5);
    check_wr("erase2", 4, {8'd22, 8'd12, 8'd11, 8'd10}, 0);
    post("erase2", 0);

    // PROBE with floor cell 205 on empty cells
    run_op(2'b11, 8'd1, {8'd32, 8'd205, 8'd31, 8'd30}, 1'b0);
    chk("probe_oor_done", done_cyc, 6);
    chk("probe_oor_nwr", wr_addr.size(), 0);
    post("probe_oor", 1);

    // PROBE all on-board empty cells: no collision; cell 199 is last valid
    run_op(2'b11, 8'd1, {8'd199, 8'd32, 8'd31, 8'd30}, 1'b0);
    chk("probe_ok_done", done_cyc, 6);
    chk("probe_ok_nwr", wr_addr.size(), 0);
    post("probe_ok", 0);

    // PROBE on cell 200, first address past the board
    run_op(2'b11, 8'd1, {8'd33, 8'd32, 8'd200, 8'd30}, 1'b0);
    chk("probe_200_done", done_cyc, 6);
    post("probe_200", 1);

    // PLACE with floor cell 205: collision clears, 3 writes
    run_op(2'b00, 8'd6, {8'd42, 8'd205, 8'd41, 8'd40}, 1'b0);
    chk("place_oor_done", done_cyc, 5);
    check_wr("place_oor", 3, {8'd0, 8'd42, 8'd41, 8'd40}, 6);
    post("place_oor", 0);

    // Reset during the second write of a PLACE
    bus.en = 1'b1; bus.mode = 2'b00; bus.color = 8'd9;
    bus.cell_addr = {8'd53, 8'd52, 8'd51, 8'd50};
    @(negedge clk);
    bus.en = 1'b0;
    chk("rstw_we1", int'(bus.mem_we), 1);
    @(negedge clk);
    chk("rstw_we2", int'(bus.mem_we), 1);
    chk("rstw_a2", int'(bus.mem_addr), 51);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_we_after", int'(bus.mem_we), 0);
    chk("rstw_busy_after", int'(bus.busy), 0);
    chk("rstw_done_after", int'(bus.done), 0);
    rst = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (bus.mem_we) nd++;
    end
    chk("rstw_no_activity", nd, 0);
    chk("rstw_ram50", int'(ram[50]), 9);
    chk("rstw_ram51", int'(ram[51]), 9);
    chk("rstw_ram52", int'(ram[52]), 0);

    // en pulsed while busy: ignored, one done only
    run_op(2'b00, 8'd1, {8'd63, 8'd62, 8'd61, 8'd60}, 1'b1);
    chk("poke_done", done_cyc, 5);
    check_wr("poke", 4, {8'd63, 8'd62, 8'd61, 8'd60}, 1);
    post("poke", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
